// File: rtl/if_pkg.sv
// Shared definitions for the instruction-fetch sequencer and its helpers.
//   - next-PC select codes driven by ID on pcsource
//   - fetch FSM state encoding
//   - word alignment helper for fetch addresses
package if_pkg;

    localparam logic [1:0] PC_SEQ = 2'd0;
    localparam logic [1:0] PC_BR  = 2'd1;
    localparam logic [1:0] PC_JR  = 2'd2;
    localparam logic [1:0] PC_J   = 2'd3;

    typedef enum logic {
        FETCH     = 1'b0,
        WAIT_SLOT = 1'b1
    } fetch_state_t;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/if_fetch_ctrl_npc_mux.sv
// Next-PC target select. Purely combinational; shared with the ID stage.
// Ports:
//   pcsource  select: PC_SEQ -> pc4, PC_BR -> bpc, PC_JR -> rpc, PC_J -> jpc
//   pc4       sequential successor
//   bpc/rpc/jpc  branch, register-jump and jump targets
//   npc       selected next PC
module npc_mux
    import if_pkg::*;
(
    input  logic [1:0]  pcsource,
    input  logic [31:0] pc4,
    input  logic [31:0] bpc,
    input  logic [31:0] rpc,
    input  logic [31:0] jpc,
    output logic [31:0] npc
);

    always_comb begin
        npc = pc4;
        case (pcsource)
            PC_BR:   npc = bpc;
            PC_JR:   npc = rpc;
            PC_J:    npc = jpc;
            default: npc = pc4;
        endcase
    end

endmodule

// File: rtl/if_fetch_ctrl.sv
// Fetch sequencer in front of the IF stage.
// Owns the PC, issues one outstanding req/ack fetch at a time, and presents
// instructions to ID through a registered output slot backed by a one-entry
// skid buffer. ID redirects are applied with MIPS delay-slot semantics.
// Ports:
//   clk, clr                 clock and synchronous active-high reset
//   pcsource, bpc, rpc, jpc  redirect select and targets from ID
//   stall                    ID is not consuming the output slot
//   imem_req/addr/ack/rdata  instruction memory port
//   if_valid/inst/pc/pc4     output slot to ID
module if_fetch_ctrl
    import if_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0000
)
(
    input  logic        clk,
    input  logic        clr,
    input  logic [1:0]  pcsource,
    input  logic [31:0] bpc,
    input  logic [31:0] rpc,
    input  logic [31:0] jpc,
    input  logic        stall,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        if_valid,
    output logic [31:0] if_inst,
    output logic [31:0] if_pc,
    output logic [31:0] if_pc4
);

    fetch_state_t state_reg, state_next;
    logic [31:0]  pc_reg, pc_next;
    logic         pend_reg, pend_next;
    logic [31:0]  tgt_reg, tgt_next;
    logic [31:0]  buf_inst_reg, buf_inst_next;
    logic [31:0]  buf_pc_reg, buf_pc_next;
    logic         valid_reg, valid_next;
    logic [31:0]  inst_reg, inst_next;
    logic [31:0]  slot_pc_reg, slot_pc_next;
    logic [31:0]  slot_pc4_reg, slot_pc4_next;

    logic         consume;
    logic         redir;
    logic [31:0]  target;
    logic [31:0]  target_al;

    npc_mux u_npc_mux (
        .pcsource (pcsource),
        .pc4      (slot_pc4_reg),
        .bpc      (bpc),
        .rpc      (rpc),
        .jpc      (jpc),
        .npc      (target)
    );

    assign target_al = word_align(target);

    // Request is masked by clr so a reset cycle never presents a live fetch.
    assign imem_req  = (state_reg == FETCH) && !clr;
    // In WAIT_SLOT the address of the word sitting in the buffer is shown,
    // i.e. the last address requested, rather than the not-yet-issued pc.
    assign imem_addr = (state_reg == FETCH) ? pc_reg : buf_pc_reg;

    assign if_valid = valid_reg;
    assign if_inst  = inst_reg;
    assign if_pc    = slot_pc_reg;
    assign if_pc4   = slot_pc4_reg;

    always_ff @(posedge clk) begin
        if (clr) begin
            state_reg    <= FETCH;
            pc_reg       <= word_align(RESET_PC);
            pend_reg     <= 1'b0;
            tgt_reg      <= 32'h0;
            buf_inst_reg <= 32'h0;
            buf_pc_reg   <= 32'h0;
            valid_reg    <= 1'b0;
            inst_reg     <= NOP_INST;
            slot_pc_reg  <= 32'h0;
            slot_pc4_reg <= 32'h0;
        end else begin
            state_reg    <= state_next;
            pc_reg       <= pc_next;
            pend_reg     <= pend_next;
            tgt_reg      <= tgt_next;
            buf_inst_reg <= buf_inst_next;
            buf_pc_reg   <= buf_pc_next;
            valid_reg    <= valid_next;
            inst_reg     <= inst_next;
            slot_pc_reg  <= slot_pc_next;
            slot_pc4_reg <= slot_pc4_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        pc_next       = pc_reg;
        pend_next     = pend_reg;
        tgt_next      = tgt_reg;
        buf_inst_next = buf_inst_reg;
        buf_pc_next   = buf_pc_reg;
        valid_next    = valid_reg;
        inst_next     = inst_reg;
        slot_pc_next  = slot_pc_reg;
        slot_pc4_next = slot_pc4_reg;

        consume = valid_reg && !stall;
        // The slot holds the branch; its delay slot is at if_pc+4, which is
        // either in flight (FETCH) or already parked in the buffer.
        redir   = consume && (pcsource != PC_SEQ);

        if (consume) begin
            valid_next = 1'b0;
            inst_next  = NOP_INST;
        end

        case (state_reg)
            FETCH: begin
                if (imem_ack) begin
                    if (!valid_reg || consume) begin
                        valid_next    = 1'b1;
                        inst_next     = imem_rdata;
                        slot_pc_next  = pc_reg;
                        slot_pc4_next = pc_reg + 32'd4;
                    end else begin
                        buf_inst_next = imem_rdata;
                        buf_pc_next   = pc_reg;
                        state_next    = WAIT_SLOT;
                    end
                    if (redir) begin
                        // Delay slot acked in the same cycle as the redirect.
                        pc_next = target_al;
                    end else if (pend_reg) begin
                        pc_next   = tgt_reg;
                        pend_next = 1'b0;
                    end else begin
                        pc_next = pc_reg + 32'd4;
                    end
                end else if (redir) begin
                    // Delay slot still outstanding: remember where to go after it.
                    pend_next = 1'b1;
                    tgt_next  = target_al;
                end
            end
            WAIT_SLOT: begin
                // Memory acks here are stray (no request) and are ignored.
                if (consume) begin
                    valid_next    = 1'b1;
                    inst_next     = buf_inst_reg;
                    slot_pc_next  = buf_pc_reg;
                    slot_pc4_next = buf_pc_reg + 32'd4;
                    state_next    = FETCH;
                    if (redir) begin
                        pc_next = target_al;
                    end
                end
            end
            default: begin
                state_next = FETCH;
            end
        endcase
    end

endmodule

// File: tb/tb_if_fetch_ctrl.sv
module tb_if_fetch_ctrl;

    logic        clk;
    logic        clr;
    logic [1:0]  pcsource;
    logic [31:0] bpc, rpc, jpc;
    logic        stall;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        if_valid;
    logic [31:0] if_inst, if_pc, if_pc4;

    if_fetch_ctrl #(.RESET_PC(32'h0), .NOP_INST(32'h0)) dut (
        .clk        (clk),
        .clr        (clr),
        .pcsource   (pcsource),
        .bpc        (bpc),
        .rpc        (rpc),
        .jpc        (jpc),
        .stall      (stall),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .if_valid   (if_valid),
        .if_inst    (if_inst),
        .if_pc      (if_pc),
        .if_pc4     (if_pc4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    // Memory agent: acks once the request has been up for mem_lat cycles.
    int mem_age = 0;
    int mem_lat = 1;

    task automatic mem_drive(input bit force_ack);
        if (force_ack) begin
            imem_ack   = 1'b1;
            imem_rdata = 32'hDEAD_BEEF;
        end else if (imem_req && mem_age >= mem_lat) begin
            imem_ack   = 1'b1;
            imem_rdata = imem_addr;
        end else begin
            imem_ack   = 1'b0;
            imem_rdata = 32'h0;
        end
    endtask

    task automatic set_targets(input logic [1:0] ps, input logic [31:0] t);
        pcsource = ps;
        bpc = (ps == 2'd1) ? t : 32'h0000_0F00;
        rpc = (ps == 2'd2) ? t : 32'h0000_0E00;
        jpc = (ps == 2'd3) ? t : 32'h0000_0D00;
    endtask

    typedef struct {
        bit          clr;
        bit          stall;
        bit          fack;
        logic [1:0]  ps;
        logic [31:0] tgt;
        bit          req;
        bit          ca;
        logic [31:0] addr;
        bit          v;
        logic [31:0] inst;
        bit          cp;
        logic [31:0] pc;
        logic [31:0] pc4;
    } vec_t;

    localparam int NV = 25;
    vec_t vec [NV];

    // Behavioural reference: program order list. Entry k+1 follows entry k
    // by +4 unless entry k-1 was a taken redirect, in which case it is the
    // target; it only becomes known once entry k-1 has been consumed.
    localparam int NORD = 8192;
    logic [31:0] ord [NORD];
    bit          is_delay [NORD];
    int          ord_len, ack_idx, deliv_idx, deliv_total, idle;

    task automatic model_reset();
        ord[0] = 32'h0;
        ord[1] = 32'h4;
        is_delay[0] = 1'b0;
        is_delay[1] = 1'b0;
        ord_len = 2;
        ack_idx = 0;
        deliv_idx = 0;
    endtask

    function automatic logic [31:0] pick_tgt();
        if ($urandom_range(0, 7) == 0) return 32'hFFFF_FFF8;
        return $urandom & 32'h0000_0FFC;
    endfunction

    initial begin
        bit req_s, ack_s, cons_s, redir_s;
        logic [31:0] tsel;

        clr = 1'b1;
        stall = 1'b0;
        imem_ack = 1'b0;
        imem_rdata = 32'h0;
        set_targets(2'd0, 32'h0);

        //           clr st fk ps tgt        req ca addr       v inst       cp pc         pc4
        vec[0]  = '{1, 0, 0, 0, 32'h0,     0, 1, 32'h0,   0, 32'h0,   1, 32'h0,   32'h0};
        vec[1]  = '{0, 0, 0, 0, 32'h0,     1, 1, 32'h0,   0, 32'h0,   1, 32'h0,   32'h0};
        vec[2]  = '{0, 0, 0, 0, 32'h0,     1, 1, 32'h0,   0, 32'h0,   0, 32'h0,   32'h0};
        vec[3]  = '{0, 0, 0, 0, 32'h0,     1, 1, 32'h4,   1, 32'h0,   1, 32'h0,   32'h4};
        vec[4]  = '{0, 0, 0, 0, 32'h0,     1, 1, 32'h4,   0, 32'h0,   0, 32'h0,   32'h0};
        vec[5]  = '{0, 1, 0, 0, 32'h0,     1, 1, 32'h8,   1, 32'h4,   1, 32'h4,   32'h8};
        vec[6]  = '{0, 1, 0, 0, 32'h0,     1, 1, 32'h8,   1, 32'h4,   1, 32'h4,   32'h8};
        vec[7]  = '{0, 1, 1, 0, 32'h0,     0, 1, 32'h8,   1, 32'h4,   1, 32'h4,   32'h8};
        vec[8]  = '{0, 0, 0, 0, 32'h0,     0, 1, 32'h8,   1, 32'h4,   1, 32'h4,   32'h8};
        vec[9]  = '{0, 0, 0, 1, 32'h40,    1, 1, 32'hC,   1, 32'h8,   1, 32'h8,   32'hC};
        vec[10] = '{0, 0, 0, 0, 32'h0,     1, 1, 32'hC,   0, 32'h0,   0, 32'h0,   32'h0};
        vec[11] = '{0, 0, 0, 0, 32'h0,     1, 1, 32'h40,  1, 32'hC,   1, 32'hC,   32'h10};
        vec[12] = '{0, 0, 0, 0, 32'h0,     1, 1, 32'h40,  0, 32'h0,   0, 32'h0,   32'h0};
        vec[13] = '{0, 0, 0, 0, 32'h0,     1, 1, 32'h44,  1, 32'h40,  1, 32'h40,  32'h44};
        vec[14] = '{0, 0, 0, 0, 32'h0,     1, 1, 32'h44,  0, 32'h0,   0, 32'h0,   32'h0};
        vec[15] = '{0, 1, 0, 0, 32'h0,     1, 1, 32'h48,  1, 32'h44,  1, 32'h44,  32'h48};
        vec[16] = '{0, 1, 0, 0, 32'h0,     1, 1, 32'h48,  1, 32'h44,  1, 32'h44,  32'h48};
        vec[17] = '{0, 0, 0, 3, 32'h100,   0, 1, 32'h48,  1, 32'h44,  1, 32'h44,  32'h48};
        vec[18] = '{0, 0, 0, 0, 32'h0,     1, 1, 32'h100, 1, 32'h48,  1, 32'h48,  32'h4C};
        vec[19] = '{0, 0, 0, 0, 32'h0,     1, 1, 32'h100, 0, 32'h0,   0, 32'h0,   32'h0};
        vec[20] = '{1, 0, 0, 0, 32'h0,     0, 0, 32'h0,   1, 32'h100, 1, 32'h100, 32'h104};
        vec[21] = '{1, 0, 1, 0, 32'h0,     0, 1, 32'h0,   0, 32'h0,   1, 32'h0,   32'h0};
        vec[22] = '{0, 0, 0, 0, 32'h0,     1, 1, 32'h0,   0, 32'h0,   1, 32'h0,   32'h0};
        vec[23] = '{0, 0, 0, 0, 32'h0,     1, 1, 32'h0,   0, 32'h0,   0, 32'h0,   32'h0};
        vec[24] = '{0, 0, 0, 0, 32'h0,     1, 1, 32'h4,   1, 32'h0,   1, 32'h0,   32'h4};

        // Directed phase: one table row per cycle, fixed 1-cycle memory.
        mem_lat = 1;
        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            clr   = vec[i].clr;
            stall = vec[i].stall;
            set_targets(vec[i].ps, vec[i].tgt);
            #1;
            mem_drive(vec[i].fack);
            chk($sformatf("row%0d imem_req", i), {31'h0, imem_req}, {31'h0, vec[i].req});
            if (vec[i].ca)
                chk($sformatf("row%0d imem_addr", i), imem_addr, vec[i].addr);
            chk($sformatf("row%0d if_valid", i), {31'h0, if_valid}, {31'h0, vec[i].v});
            chk($sformatf("row%0d if_inst", i), if_inst, vec[i].inst);
            if (vec[i].cp) begin
                chk($sformatf("row%0d if_pc", i), if_pc, vec[i].pc);
                chk($sformatf("row%0d if_pc4", i), if_pc4, vec[i].pc4);
            end
            $display("row %0d: clr=%0d stall=%0d ps=%0d req=%0d addr=%h ack=%0d valid=%0d pc=%h inst=%h",
                     i, clr, stall, pcsource, imem_req, imem_addr, imem_ack, if_valid, if_pc, if_inst);
            req_s = imem_req;
            ack_s = imem_ack;
            @(posedge clk);
            mem_age = (req_s && !ack_s) ? mem_age + 1 : 0;
        end

        // Random phase against the program-order model.
        model_reset();
        deliv_total = 0;
        idle = 0;
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            clr   = (i < 2) || ($urandom_range(0, 299) == 0);
            stall = ($urandom_range(0, 9) < 3);
            if (if_valid && is_delay[deliv_idx])
                pcsource = 2'd0;
            else
                pcsource = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
            bpc = pick_tgt();
            rpc = pick_tgt();
            jpc = pick_tgt();
            #1;
            if (!imem_req && $urandom_range(0, 19) == 0)
                mem_drive(1'b1);
            else
                mem_drive(1'b0);

            cons_s  = if_valid && !stall && !clr;
            redir_s = cons_s && (pcsource != 2'd0);
            case (pcsource)
                2'd1:    tsel = bpc;
                2'd2:    tsel = rpc;
                default: tsel = jpc;
            endcase

            if (imem_req) begin
                if (ack_idx >= ord_len) begin
                    n_assert++;
                    n_fail++;
                    $display("FAIL premature_fetch: got addr %h required no request (index %0d)", imem_addr, ack_idx);
                end else begin
                    chk("fetch_addr", imem_addr, ord[ack_idx]);
                end
                chk("addr_align", {30'h0, imem_addr[1:0]}, 32'h0);
            end
            if (cons_s) begin
                chk("deliver_pc", if_pc, ord[deliv_idx]);
                chk("deliver_inst", if_inst, ord[deliv_idx]);
                chk("deliver_pc4", if_pc4, ord[deliv_idx] + 32'd4);
                $display("deliver %0d: pc=%h inst=%h redirect=%0d tgt=%h", deliv_total, if_pc, if_inst, redir_s, tsel);
            end
            if (!if_valid)
                chk("nop_when_invalid", if_inst, 32'h0);

            if (cons_s || clr) idle = 0;
            else idle++;
            if (idle > 100) begin
                n_assert++;
                n_fail++;
                $display("FAIL progress: got %0d idle cycles required at most 100", idle);
                idle = 0;
            end

            req_s = imem_req;
            ack_s = imem_ack;
            @(posedge clk);
            if (req_s && !ack_s) begin
                mem_age++;
            end else begin
                mem_age = 0;
                mem_lat = $urandom_range(1, 3);
            end
            if (clr) begin
                model_reset();
            end else begin
                if (req_s && ack_s) ack_idx++;
                if (cons_s) begin
                    ord[deliv_idx + 2]      = redir_s ? {tsel[31:2], 2'b00} : ord[deliv_idx + 1] + 32'd4;
                    is_delay[deliv_idx + 1] = redir_s;
                    is_delay[deliv_idx + 2] = 1'b0;
                    ord_len = deliv_idx + 3;
                    deliv_idx++;
                    deliv_total++;
                end
            end
        end

        n_assert++;
        if (deliv_total < 300) begin
            n_fail++;
            $display("FAIL throughput: got %0d deliveries required at least 300", deliv_total);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
